// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the dual-core sfp_row sequencer: FSM state encoding and sum-bus width derivation.
// The partial-sum width is 2*bw+4 and the sum bus adds 4 bits of headroom on top of it.
package sfp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP1 = 3'd1,
    S_RD   = 3'd2,
    S_GAP2 = 3'd3,
    S_DIV1 = 3'd4,
    S_DIV2 = 3'd5,
    S_OUT  = 3'd6
  } state_e;

  function automatic int psum_width(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int sum_width(input int w);
    return psum_width(w) + 4;
  endfunction

endpackage

// File: rtl/sfp_dualcore_ctrl.sv
// Row sequencer for two sfp_row cores: accept -> out_valid in 6 cycles, min row period 7.
// Backpressure: row_ready only in IDLE; OUT holds out_valid and sum_in stable until out_ready.
module sfp_dualcore_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int bw     = 8,
  parameter int ROWS   = 8,
  parameter int RCNT_W = 3,
  localparam int SW    = sum_width(bw)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dual_en,
  input  logic              row_valid,
  output logic              row_ready,
  output logic              acc,
  output logic              fifo_ext_rd0,
  output logic              fifo_ext_rd1,
  input  logic [SW-1:0]     sum_out0,
  input  logic [SW-1:0]     sum_out1,
  output logic [SW-1:0]     sum_in0,
  output logic [SW-1:0]     sum_in1,
  output logic              div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RCNT_W-1:0] row_idx,
  output logic              frame_done,
  output logic              busy
);

  state_e              state_q;
  logic                dual_q;
  logic                rd_q;
  logic                div_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [SW-1:0]       sum_in0_q;
  logic [SW-1:0]       sum_in1_q;
  logic [RCNT_W-1:0]   row_idx_q;
  logic [RCNT_W-1:0]   row_idx_d;
  logic                last_row;

  assign last_row  = (row_idx_q == RCNT_W'(ROWS - 1));
  assign row_idx_d = last_row ? '0 : row_idx_q + 1'b1;

  // Strobes for the current state are set one edge early so they are plain flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dual_q      <= 1'b0;
      rd_q        <= 1'b0;
      div_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_in0_q   <= '0;
      sum_in1_q   <= '0;
      row_idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (row_valid) begin
            state_q   <= S_GAP1;
            dual_q    <= dual_en;
            sum_in0_q <= '0;
            sum_in1_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_GAP1: begin
          state_q <= S_RD;
          rd_q    <= 1'b1;
        end
        S_RD: begin
          state_q <= S_GAP2;
          rd_q    <= 1'b0;
          if (dual_q) begin
            sum_in0_q <= sum_out1;
            sum_in1_q <= sum_out0;
          end
        end
        S_GAP2: begin
          state_q <= S_DIV1;
          div_q   <= 1'b1;
        end
        S_DIV1: begin
          state_q <= S_DIV2;
        end
        S_DIV2: begin
          state_q     <= S_OUT;
          div_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            row_idx_q   <= row_idx_d;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rd_q        <= 1'b0;
          div_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign row_ready    = (state_q == S_IDLE);
  assign acc          = row_ready & row_valid;
  assign fifo_ext_rd0 = rd_q;
  assign fifo_ext_rd1 = rd_q;
  assign div          = div_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign sum_in0      = sum_in0_q;
  assign sum_in1      = sum_in1_q;
  assign row_idx      = row_idx_q;
  assign frame_done   = out_valid_q & out_ready & last_row;

endmodule
